// File: rtl/fifo_rd_stream.sv
// Purpose : pops words from the async FIFO read port and re-presents them as a valid/ready stream.
// Latency : 1 clk pop->m_valid with RD_LAT=0, 2 clk with RD_LAT=1; sustains 1 word/clk.
// Backpressure: 2-entry buffer; rinc stops once buffered + in-flight words reach 2; m_data held while stalled.
//
// Ports:
//   rclk, rrst_n        read clock, async active-low reset
//   rempty, rdata, rinc FIFO read port (empty flag, data, pop strobe)
//   flush               sync discard of buffered and in-flight words
//   m_valid, m_data,
//   m_ready             output stream
//   busy                buffer non-empty or a pop is in flight
//   rd_cnt, ovr_err     only with FIFO_RD_STATS_EN defined: deq counter, sticky overflow flag
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 0
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]           rd_cnt,
  output logic                  ovr_err
`endif
);

  logic                  en_q, en_d;
  logic [1:0]            occ_q, occ_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];

  logic       deq;
  logic       inflight_use;
  logic [2:0] pend;
  logic       capture;
  logic       wr_ok;

  assign deq          = (occ_q != 2'd0) & m_ready;
  assign inflight_use = (RD_LAT == 1) ? inflight_q : 1'b0;
  // Words this block will own after the current edge, excluding a new pop.
  assign pend         = {1'b0, occ_q} + {2'b00, inflight_use} - {2'b00, deq};
  assign rinc         = en_q & ~rempty & ~flush & (pend < 3'd2);
  // With RD_LAT=1 the word lands one edge after its pop; a flush on that edge drops it.
  assign capture      = (RD_LAT == 1) ? (inflight_q & ~flush) : rinc;
  // Never overwrite a full buffer; the pop rule should make this unreachable.
  assign wr_ok        = capture & ~((occ_q == 2'd2) & ~deq);

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf_q[rd_ptr_q];
  assign busy    = (occ_q != 2'd0) | inflight_use;

  always_comb begin
    en_d       = 1'b1;
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = (RD_LAT == 1) ? rinc : 1'b0;
    buf_d      = buf_q;
    if (flush) begin
      occ_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (wr_ok) begin
        buf_d[wr_ptr_q] = rdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (deq) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      occ_d = occ_q + {1'b0, wr_ok} - {1'b0, deq};
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      en_q       <= 1'b0;
      occ_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      en_q       <= en_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
      buf_q      <= buf_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic        ovr_err_q, ovr_err_d;

  always_comb begin
    rd_cnt_d  = flush ? 16'd0 : (rd_cnt_q + {15'd0, deq});
    ovr_err_d = ovr_err_q | (capture & (occ_q == 2'd2) & ~deq);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_cnt_q  <= 16'd0;
      ovr_err_q <= 1'b0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      ovr_err_q <= ovr_err_d;
    end
  end

  assign rd_cnt  = rd_cnt_q;
  assign ovr_err = ovr_err_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: one instance per read latency, shared sink/flush/reset stimulus,
// per-lane FIFO model, scoreboard queues filled at pop time and drained by an independent monitor.
module tb_fifo_rd_stream;
  localparam int DW   = 8;
  localparam int MEMN = 8192;

  logic rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic          rrst_n, flush, m_ready;
  logic [1:0]    rempty, rinc, m_valid, busy;
  logic [DW-1:0] rdata  [2];
  logic [DW-1:0] m_data [2];
`ifdef FIFO_RD_STATS_EN
  logic [15:0]   rd_cnt [2];
  logic [1:0]    ovr_err;
`endif

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LAT(0)) u_lat0 (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty[0]), .rdata(rdata[0]), .rinc(rinc[0]),
    .flush(flush), .m_valid(m_valid[0]), .m_data(m_data[0]), .m_ready(m_ready), .busy(busy[0])
`ifdef FIFO_RD_STATS_EN
    , .rd_cnt(rd_cnt[0]), .ovr_err(ovr_err[0])
`endif
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LAT(1)) u_lat1 (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty[1]), .rdata(rdata[1]), .rinc(rinc[1]),
    .flush(flush), .m_valid(m_valid[1]), .m_data(m_data[1]), .m_ready(m_ready), .busy(busy[1])
`ifdef FIFO_RD_STATS_EN
    , .rd_cnt(rd_cnt[1]), .ovr_err(ovr_err[1])
`endif
  );

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] mem [MEMN];
  int            next_w [2];
  int            lim [2];
  int            pops [2];
  int            rd_model [2];
  logic          force_empty;
  logic [DW-1:0] exp0 [$];
  logic [DW-1:0] exp1 [$];
  logic [1:0]    rinc_s, popped_last, hold_prev;
  logic [DW-1:0] held [2];
  logic          flush_s;
  int            base, p0, p1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int qsize(input int l);
    return (l == 0) ? exp0.size() : exp1.size();
  endfunction

  // FIFO model: lane reads mem[next_w], empty when next_w reaches lim or forced empty.
  task automatic drive_fifo();
    for (int l = 0; l < 2; l++) rempty[l] = force_empty | (next_w[l] >= lim[l]);
    rdata[0] = rempty[0] ? DW'($urandom) : mem[next_w[0]];
    rdata[1] = popped_last[1] ? mem[next_w[1] - 1] : DW'($urandom);
  endtask

  // Account for the pops that happened on the edge just passed.
  task automatic commit();
    if (flush_s) begin
      exp0.delete();
      exp1.delete();
    end
    for (int l = 0; l < 2; l++) begin
      if (rinc_s[l]) begin
        if (l == 0) exp0.push_back(mem[next_w[0]]);
        else        exp1.push_back(mem[next_w[1]]);
        next_w[l]++;
        pops[l]++;
      end
      popped_last[l] = rinc_s[l];
    end
    rinc_s  = 2'b00;
    flush_s = 1'b0;
  endtask

  task automatic step(input logic mr, input logic fl, input logic fe);
    @(posedge rclk);
    #1;
    commit();
    m_ready     = mr & ~fl;
    flush       = fl;
    force_empty = fe;
    drive_fifo();
    @(negedge rclk);
    for (int l = 0; l < 2; l++) check("rinc_gate", rinc[l] & (rempty[l] | flush), 0);
    rinc_s  = rinc;
    flush_s = flush;
  endtask

  task automatic do_reset();
    @(posedge rclk);
    #1;
    commit();
    drive_fifo();
    #2;
    rrst_n = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) begin
      check("rst_rinc", rinc[l], 0);
      check("rst_m_valid", m_valid[l], 0);
      check("rst_busy", busy[l], 0);
`ifdef FIFO_RD_STATS_EN
      check("rst_rd_cnt", rd_cnt[l], 0);
      check("rst_ovr_err", ovr_err[l], 0);
`endif
    end
    exp0.delete();
    exp1.delete();
    popped_last = 2'b00;
    flush       = 1'b0;
    m_ready     = 1'b0;
    drive_fifo();
    repeat (2) @(posedge rclk);
    #2;
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    drive_fifo();
    @(negedge rclk);
    for (int l = 0; l < 2; l++) check("rinc_first_cycle", rinc[l], 0);
    rinc_s  = rinc;
    flush_s = flush;
  endtask

  // Stop popping and let everything owned by the DUTs drain out.
  task automatic drain();
    for (int l = 0; l < 2; l++) lim[l] = next_w[l];
    repeat (6) step(1'b1, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) check("drain_empty", qsize(l), 0);
  endtask

  // Start both lane FIFO models at a fresh common read index.
  task automatic realign(input int nwords);
    base = ((next_w[0] > next_w[1]) ? next_w[0] : next_w[1]) + 8;
    for (int l = 0; l < 2; l++) begin
      next_w[l] = base;
      lim[l]    = base + nwords;
    end
    p0 = pops[0];
    p1 = pops[1];
  endtask

  // Monitor / scoreboard: checks status outputs every cycle and pops on each handshake.
  initial begin
    int sz;
    int inflight;
    hold_prev = 2'b00;
    rd_model  = '{0, 0};
    forever begin
      @(negedge rclk);
      if (!rrst_n) begin
        hold_prev = 2'b00;
        rd_model  = '{0, 0};
      end else begin
        for (int l = 0; l < 2; l++) begin
          sz       = qsize(l);
          inflight = (l == 1) ? int'(popped_last[1]) : 0;
          check("busy", busy[l], (sz != 0));
          check("m_valid", m_valid[l], ((sz - inflight) > 0));
`ifdef FIFO_RD_STATS_EN
          check("rd_cnt", rd_cnt[l], rd_model[l] & 16'hFFFF);
          check("ovr_err", ovr_err[l], 0);
`endif
          if (hold_prev[l] && m_valid[l]) check("m_data_hold", m_data[l], held[l]);
          if (m_valid[l] && m_ready) begin
            check("deq_has_expected", (sz > 0), 1);
            if (sz > 0) begin
              if (l == 0) check("m_data_lat0", m_data[0], exp0.pop_front());
              else        check("m_data_lat1", m_data[1], exp1.pop_front());
            end
            rd_model[l]++;
          end
          hold_prev[l] = m_valid[l] & ~m_ready & ~flush;
          held[l]      = m_data[l];
        end
        if (flush) rd_model = '{0, 0};
      end
    end
  end

  initial begin
    rrst_n      = 1'b0;
    flush       = 1'b0;
    m_ready     = 1'b0;
    force_empty = 1'b0;
    rinc_s      = 2'b00;
    popped_last = 2'b00;
    flush_s     = 1'b0;
    for (int i = 0; i < MEMN; i++) mem[i] = DW'($urandom);
    for (int l = 0; l < 2; l++) begin
      next_w[l] = 0;
      lim[l]    = 1;
      pops[l]   = 0;
    end
    mem[0] = 8'hA5;
    drive_fifo();

    // Reset, first pop gated, first word A5.
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    check("t1_first_pop0", rinc_s[0], 1);
    check("t1_first_pop1", rinc_s[1], 1);
    step(1'b1, 1'b0, 1'b0);
    check("t1_m_valid", m_valid[0], 1);
    check("t1_m_data", m_data[0], 8'hA5);
    drain();

    // 16-word stream, sink always ready: one pop every cycle.
    realign(16);
    for (int k = 0; k < 16; k++) mem[base + k] = DW'(k);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 1'b0);
      check("t2_pop_lat0", rinc_s[0], 1);
      check("t2_pop_lat1", rinc_s[1], 1);
    end
    drain();
    check("t2_count0", pops[0] - p0, 16);
    check("t2_count1", pops[1] - p1, 16);

    // Sink stalled with 5 words available: exactly 2 pops, head held.
    realign(5);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) begin
      check("t3_stall_pops", pops[l] - ((l == 0) ? p0 : p1), 2);
      check("t3_stall_valid", m_valid[l], 1);
      check("t3_stall_head", m_data[l], mem[base]);
    end
    repeat (10) step(1'b1, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) begin
      check("t3_all_popped", next_w[l], lim[l]);
      check("t3_all_delivered", qsize(l), 0);
    end

    // FIFO runs dry after 3 words.
    realign(3);
    repeat (8) step(1'b1, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) begin
      check("t4_pops", pops[l] - ((l == 0) ? p0 : p1), 3);
      check("t4_busy_low", busy[l], 0);
    end

    // Flush mid-stream with a word in flight on the RD_LAT=1 lane.
    realign(100);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) check("t5_valid_after_flush", m_valid[l], 0);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    drain();

    // Random sink readiness, flushes, empty bursts and one mid-stream reset.
    realign(MEMN - 3000);
    for (int i = 0; i < 900; i++) begin
      if (i == 450) do_reset();
      else step(($urandom % 100) < 70, ($urandom % 100) < 4, ($urandom % 100) < 20);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
